// File: rtl/peak_report_packer.sv
`default_nettype none
// ============================================================================
// Module   : peak_report_packer
// Purpose  : Captures the two-peak detector's per-frame result on each
//            last_out pulse, buffers it in a small FIFO, and serialises it as
//            a 4-word, 32-bit AXI-Stream packet. Reports that arrive while
//            the FIFO is full (and nothing is leaving) are counted as drops.
// Ports    : clk, aresetn            - clock, asynchronous active-low reset
//            last_out                - report strobe; peak inputs valid now
//            peak1_final/peak2_final - peak values (VALUE_W bits)
//            index1_final/index2_final - peak indices (INDEX_W bits)
//            m_tvalid/m_tready/m_tdata/m_tlast - AXI-Stream master
//            fifo_level              - queued reports (excludes the one being
//                                      serialised)
//            drop_count              - saturating count of lost reports
// Revision : 1.0 - initial release
// ============================================================================

`ifndef VALUE_WIDTH
`define VALUE_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 16
`endif

module peak_report_packer #(
   parameter int VALUE_W = `VALUE_WIDTH,   // <= 32
   parameter int INDEX_W = `INDEX_WIDTH,   // <= 16
   parameter int DEPTH   = 4               // power of two, >= 2
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       last_out,
   input  logic [VALUE_W-1:0]         peak1_final,
   input  logic [VALUE_W-1:0]         peak2_final,
   input  logic [INDEX_W-1:0]         index1_final,
   input  logic [INDEX_W-1:0]         index2_final,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [31:0]                m_tdata,
   output logic                       m_tlast,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [7:0]         seq;
      logic [VALUE_W-1:0] p1;
      logic [VALUE_W-1:0] p2;
      logic [INDEX_W-1:0] i1;
      logic [INDEX_W-1:0] i2;
   } report_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_W0   = 3'd1,
      S_W1   = 3'd2,
      S_W2   = 3'd3,
      S_W3   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   report_t        mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  count_q,  count_d;
   logic [7:0]     seq_q,    seq_d;
   logic [7:0]     drop_q,   drop_d;

   state_t         state_q,  state_d;
   logic           tvalid_q, tvalid_d;
   logic           tlast_q,  tlast_d;
   logic [31:0]    tdata_q,  tdata_d;

   // Words 1..3 of the packet in flight, prepared at pop time so each beat
   // is a plain register-to-register move.
   logic [31:0]    w1_q, w1_d;
   logic [31:0]    w2_q, w2_d;
   logic [31:0]    w3_q, w3_d;

   logic           w_empty;
   logic           w_full;
   logic           w_hs;
   logic           w_pop;
   logic           w_push;
   logic           w_drop;
   report_t        w_head;
   report_t        w_new;
   logic [31:0]    w_head_w0;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == LW'(DEPTH));
   assign w_hs    = tvalid_q & m_tready;
   assign w_head  = mem_q[rd_ptr_q];

   assign w_new.seq = seq_q;
   assign w_new.p1  = peak1_final;
   assign w_new.p2  = peak2_final;
   assign w_new.i1  = index1_final;
   assign w_new.i2  = index2_final;

   // Header word: the drop field is the counter value at the pop edge, so a
   // report popped before an overflow never shows that overflow.
   assign w_head_w0 = {8'hA5, w_head.seq, drop_q, 7'd0, (w_head.i1 < w_head.i2)};

   // A full FIFO still accepts a report when an entry leaves on the same
   // edge; the freed slot is the one being written.
   assign w_push = last_out & (~w_full | w_pop);
   assign w_drop = last_out & w_full & ~w_pop;

   // ------------------------------------------------------------------------
   // Serialiser next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      w_pop    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
            end
         end
         S_W0: begin
            if (w_hs) begin
               state_d = S_W1;
               tdata_d = w1_q;
            end
         end
         S_W1: begin
            if (w_hs) begin
               state_d = S_W2;
               tdata_d = w2_q;
            end
         end
         S_W2: begin
            if (w_hs) begin
               state_d = S_W3;
               tdata_d = w3_q;
               tlast_d = 1'b1;
            end
         end
         S_W3: begin
            if (w_hs) begin
               if (!w_empty) begin
                  // Next packet starts on the very next beat.
                  w_pop = 1'b1;
               end else begin
                  state_d  = S_IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = 32'd0;
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 32'd0;
         end
      endcase

      if (w_pop) begin
         state_d  = S_W0;
         tvalid_d = 1'b1;
         tlast_d  = 1'b0;
         tdata_d  = w_head_w0;
      end
   end

   // ------------------------------------------------------------------------
   // FIFO bookkeeping, counters and packet word preparation
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      seq_d    = seq_q;
      drop_d   = drop_q;
      w1_d     = w1_q;
      w2_d     = w2_q;
      w3_d     = w3_q;

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         w1_d     = 32'(w_head.p1);
         w2_d     = 32'(w_head.p2);
         w3_d     = {16'(w_head.i2), 16'(w_head.i1)};
      end

      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Every report event advances the sequence, accepted or not.
      if (last_out) begin
         seq_d = seq_q + 8'd1;
      end
      if (w_drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= 32'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         seq_q    <= 8'd0;
         drop_q   <= 8'd0;
         w1_q     <= 32'd0;
         w2_q     <= 32'd0;
         w3_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         seq_q    <= seq_d;
         drop_q   <= drop_d;
         w1_q     <= w1_d;
         w2_q     <= w2_d;
         w3_q     <= w3_d;
      end
   end

   // Payload storage carries no reset: emptiness is defined by the pointers
   // and count, which are cleared asynchronously.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_new;
      end
   end

   assign m_tvalid   = tvalid_q;
   assign m_tdata    = tdata_q;
   assign m_tlast    = tlast_q;
   assign fifo_level = count_q;
   assign drop_count = drop_q;

endmodule

`default_nettype wire
